// File: rtl/subcarrier_mapper.sv
// ============================================================================
//  Module      : subcarrier_mapper
//  Description : Maps a stream of data samples onto the slots of an OFDM
//                symbol, inserting null slots (DC + guard band) and
//                polarity-scrambled pilots. Wishbone-style sink and source,
//                registered output stage with 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subcarrier_mapper #(
    parameter int                                   DW         = 32,
    parameter int                                   N_FFT      = 256,
    parameter int                                   GUARD_LO   = 101,
    parameter int                                   GUARD_HI   = 155,
    parameter int                                   NUM_PILOTS = 8,
    parameter logic [NUM_PILOTS*$clog2(N_FFT)-1:0]  PILOT_POS  = {8'd242, 8'd217, 8'd192, 8'd167,
                                                                  8'd87,  8'd62,  8'd37,  8'd12},
    parameter logic [NUM_PILOTS-1:0]                PILOT_PAT  = 8'b0000_0000,
    parameter logic [DW/2-1:0]                      PILOT_AMP  = 16'h7FFF,
    parameter logic [10:0]                          LFSR_SEED  = 11'h7FF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    // data sink
    input  logic [DW-1:0] DAT_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    output logic          ACK_O,
    // data source
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I,
    // start-of-symbol marker for the beat on DAT_O
    output logic          SOS_O
);

    localparam int             SW        = $clog2(N_FFT);
    localparam int             HW        = DW / 2;
    localparam logic [SW-1:0]  SLOT_LAST = SW'(N_FFT - 1);
    localparam logic [SW-1:0]  SLOT_GLO  = SW'(GUARD_LO);
    localparam logic [SW-1:0]  SLOT_GHI  = SW'(GUARD_HI);
    localparam logic [HW-1:0]  NEG_AMP   = ~PILOT_AMP + HW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q,  slot_d;
    logic [10:0]     lfsr_q,  lfsr_d;
    logic [DW-1:0]   dat_q,   dat_d;
    logic            stb_q,   stb_d;
    logic            cyc_q,   cyc_d;
    logic            sos_q,   sos_d;

    logic [NUM_PILOTS-1:0] w_pilot_hit;
    logic            w_is_null;
    logic            w_is_pilot;
    logic            w_is_data;
    logic            w_pilot_neg;
    logic [HW-1:0]   w_pilot_re;
    logic [DW-1:0]   w_pilot_val;
    logic            w_load_en;
    logic            w_ack;
    logic            w_load;
    logic [DW-1:0]   w_load_val;
    logic [SW-1:0]   w_slot_next;
    logic [10:0]     w_lfsr_step;

    // One comparator per pilot position
    generate
        for (genvar p = 0; p < NUM_PILOTS; p++) begin : g_pilot
            assign w_pilot_hit[p] = (slot_q == PILOT_POS[p*SW +: SW]);
        end
    endgenerate

    // Slot classification: NULL wins over PILOT, everything else is DATA
    assign w_is_null   = (slot_q == '0) || ((slot_q >= SLOT_GLO) && (slot_q <= SLOT_GHI));
    assign w_is_pilot  = ~w_is_null & (|w_pilot_hit);
    assign w_is_data   = ~w_is_null & ~w_is_pilot;

    // Pilot polarity: symbol-wide scrambler bit xor the per-pilot base pattern
    assign w_pilot_neg = lfsr_q[10] ^ (|(w_pilot_hit & PILOT_PAT));
    assign w_pilot_re  = w_pilot_neg ? NEG_AMP : PILOT_AMP;
    assign w_pilot_val = {{(DW-HW){1'b0}}, w_pilot_re};

    assign w_load_en   = ~stb_q | ACK_I;
    assign w_ack       = CYC_I & STB_I & WE_I & w_load_en & (state_q == ST_RUN) & w_is_data;
    assign w_slot_next = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    assign w_lfsr_step = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};

    assign ACK_O = w_ack;
    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = cyc_q;
    assign SOS_O = sos_q;

    // Next-state logic: FSM transitions and output-register loading
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        lfsr_d     = lfsr_q;
        dat_d      = dat_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        sos_d      = sos_q;
        w_load     = 1'b0;
        w_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (CYC_I) begin
                    state_d = ST_RUN;
                    slot_d  = '0;
                    lfsr_d  = LFSR_SEED;
                    cyc_d   = 1'b1;
                end
            end

            ST_RUN: begin
                if (!CYC_I) begin
                    // Upstream ended: finish the symbol with padding, or just drain
                    state_d = (slot_q == '0) ? ST_DRAIN : ST_PAD;
                    if (w_load_en) begin
                        stb_d = 1'b0;
                        sos_d = 1'b0;
                    end
                end else if (w_load_en) begin
                    if (w_is_null) begin
                        w_load = 1'b1;
                    end else if (w_is_pilot) begin
                        w_load     = 1'b1;
                        w_load_val = w_pilot_val;
                    end else if (w_ack) begin
                        w_load     = 1'b1;
                        w_load_val = DAT_I;
                    end else begin
                        // Data slot with no sample offered: emit nothing, hold slot
                        stb_d = 1'b0;
                        sos_d = 1'b0;
                    end
                end
            end

            ST_PAD: begin
                if (w_load_en) begin
                    w_load     = 1'b1;
                    w_load_val = w_is_pilot ? w_pilot_val : '0;
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (ACK_I) begin
                    stb_d = 1'b0;
                    sos_d = 1'b0;
                end
                if (!stb_q || ACK_I) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common output load: advance slot, step scrambler at end of symbol
        if (w_load) begin
            dat_d  = w_load_val;
            stb_d  = 1'b1;
            sos_d  = (slot_q == '0);
            slot_d = w_slot_next;
            if (slot_q == SLOT_LAST) begin
                lfsr_d = w_lfsr_step;
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            sos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            lfsr_q  <= lfsr_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            sos_q   <= sos_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subcarrier_mapper.sv
// ============================================================================
//  Module      : tb_subcarrier_mapper
//  Description : Directed self-checking bench for subcarrier_mapper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subcarrier_mapper;

    localparam int          DW        = 32;
    localparam int          NSLOT     = 256;
    localparam int          NDATA     = 192;
    // Seed 11'h7FF gives lfsr[10]=1 for the first three symbols -> -0x7FFF
    localparam logic [31:0] PILOT_EXP = 32'h0000_8001;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b0;
    logic [DW-1:0] DAT_I = '0;
    logic          CYC_I = 1'b0;
    logic          STB_I = 1'b0;
    logic          WE_I  = 1'b0;
    logic          ACK_O;
    logic [DW-1:0] DAT_O;
    logic          CYC_O;
    logic          STB_O;
    logic          WE_O;
    logic          ACK_I = 1'b0;
    logic          SOS_O;

    int tests = 0;
    int fails = 0;

    subcarrier_mapper dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .DAT_I (DAT_I),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ACK_O (ACK_O),
        .DAT_O (DAT_O),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ACK_I (ACK_I),
        .SOS_O (SOS_O)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic bit is_null(input int s);
        return (s == 0) || (s >= 101 && s <= 155);
    endfunction

    function automatic bit is_pilot(input int s);
        case (s)
            12, 37, 62, 87, 167, 192, 217, 242: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Drive a framed stream from IDLE and check every output beat.
    // Upstream offers a ramp 1,2,3..; CYC_I drops after drop_after accepted samples.
    task automatic stream(input int n_syms, input int ack_pct, input int stb_pct,
                          input int drop_after, input string tag, output int gaps);
        int          beats    = 0;
        int          acks     = 0;
        int          data_idx = 0;
        int          cyc      = 0;
        int          extra    = 0;
        int          cur_in   = 1;
        int          slot;
        bit          dropped  = 1'b0;
        bit          hold     = 1'b0;
        logic [31:0] hold_dat = '0;
        logic        hold_sos = 1'b0;
        logic [31:0] exp_val;
        gaps = 0;
        while (beats < n_syms * NSLOT && cyc < 20000) begin
            @(posedge CLK_I);
            #1;
            ACK_I = ($urandom_range(99) < ack_pct);
            STB_I = ($urandom_range(99) < stb_pct);
            WE_I  = 1'b1;
            DAT_I = cur_in;
            CYC_I = !dropped;
            #1;
            cyc++;
            if (hold) begin
                tests++;
                if (STB_O !== 1'b1 || DAT_O !== hold_dat || SOS_O !== hold_sos) begin
                    fails++;
                    $display("FAIL %s stall_hold: got stb=%b dat=%h sos=%b want stb=1 dat=%h sos=%b",
                             tag, STB_O, DAT_O, SOS_O, hold_dat, hold_sos);
                end
            end
            tests++;
            if (WE_O !== STB_O) begin
                fails++;
                $display("FAIL %s we_o: got %b want %b", tag, WE_O, STB_O);
            end
            if (!STB_I || !CYC_I) begin
                tests++;
                if (ACK_O !== 1'b0) begin
                    fails++;
                    $display("FAIL %s ack_no_req: got %b want 0", tag, ACK_O);
                end
            end
            if (ACK_O === 1'b1) begin
                acks++;
                cur_in++;
                if (acks == drop_after) dropped = 1'b1;
            end
            if (beats > 0 && STB_O !== 1'b1) gaps++;
            if (STB_O === 1'b1 && ACK_I) begin
                slot = beats % NSLOT;
                if (is_null(slot)) begin
                    exp_val = 32'h0;
                end else if (is_pilot(slot)) begin
                    exp_val = PILOT_EXP;
                end else begin
                    exp_val = (data_idx >= drop_after) ? 32'h0 : 32'(data_idx + 1);
                    data_idx++;
                end
                tests++;
                if (DAT_O !== exp_val) begin
                    fails++;
                    $display("FAIL %s beat_data: beat %0d slot %0d got %h want %h",
                             tag, beats, slot, DAT_O, exp_val);
                end
                tests++;
                if (SOS_O !== (slot == 0)) begin
                    fails++;
                    $display("FAIL %s sos: beat %0d slot %0d got %b want %b",
                             tag, beats, slot, SOS_O, (slot == 0));
                end
                beats++;
            end
            hold     = (STB_O === 1'b1) && !ACK_I;
            hold_dat = DAT_O;
            hold_sos = SOS_O;
        end
        tests++;
        if (cyc >= 20000) begin
            fails++;
            $display("FAIL %s timeout: got %0d beats want %0d", tag, beats, n_syms * NSLOT);
        end
        // Drain: source accepts, upstream idle; CYC_O must fall with no extra beats
        CYC_I = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK_I);
            #1;
            ACK_I = 1'b1;
            STB_I = 1'b0;
            #1;
            if (STB_O === 1'b1) extra++;
            if (CYC_O === 1'b0) break;
        end
        tests++;
        if (CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL %s cyc_o_fall: got %b want 0", tag, CYC_O);
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL %s extra_beats: got %0d want 0", tag, extra);
        end
        tests++;
        if (acks != drop_after) begin
            fails++;
            $display("FAIL %s ack_count: got %0d want %0d", tag, acks, drop_after);
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        ACK_I = 1'b1;
        DAT_I = 32'h1234_5678;
        repeat (3) @(posedge CLK_I);
        #1;
        tests++;
        if (DAT_O !== 32'h0) begin fails++; $display("FAIL reset_dat: got %h want 0", DAT_O); end
        tests++;
        if (STB_O !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", STB_O); end
        tests++;
        if (CYC_O !== 1'b0) begin fails++; $display("FAIL reset_cyc: got %b want 0", CYC_O); end
        tests++;
        if (SOS_O !== 1'b0) begin fails++; $display("FAIL reset_sos: got %b want 0", SOS_O); end
        tests++;
        if (ACK_O !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ACK_O); end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b1;
        repeat (4) @(posedge CLK_I);
        #1;
        tests++;
        if (STB_O !== 1'b0 || CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got stb=%b cyc=%b want 0 0", STB_O, CYC_O);
        end
    endtask

    task automatic test_single_symbol();
        int gaps;
        stream(1, 100, 100, NDATA, "ramp", gaps);
        tests++;
        if (gaps != 0) begin fails++; $display("FAIL ramp_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_back_to_back();
        int gaps;
        stream(3, 100, 100, 3 * NDATA, "b2b", gaps);
        tests++;
        if (gaps != 0) begin fails++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_ack_stall();
        int gaps;
        stream(1, 50, 100, NDATA, "stall", gaps);
    endtask

    task automatic test_cyc_drop();
        int gaps;
        stream(1, 100, 100, 50, "cycdrop", gaps);
    endtask

    task automatic test_stb_gaps();
        int gaps;
        stream(1, 100, 60, NDATA, "stbgap", gaps);
    endtask

    task automatic test_reset_mid();
        int beats  = 0;
        int cyc    = 0;
        int cur_in = 1;
        int gaps;
        while (beats < 130 && cyc < 2000) begin
            @(posedge CLK_I);
            #1;
            CYC_I = 1'b1;
            STB_I = 1'b1;
            WE_I  = 1'b1;
            ACK_I = 1'b1;
            DAT_I = cur_in;
            #1;
            cyc++;
            if (ACK_O === 1'b1) cur_in++;
            if (STB_O === 1'b1) beats++;
        end
        tests++;
        if (beats != 130) begin
            fails++;
            $display("FAIL rstmid_reach: got %0d beats want 130", beats);
        end
        RST_I = 1'b0;
        #1;
        tests++;
        if (STB_O !== 1'b0 || CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: got stb=%b cyc=%b want 0 0", STB_O, CYC_O);
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b1;
        repeat (5) @(posedge CLK_I);
        #1;
        tests++;
        if (STB_O !== 1'b0 || CYC_O !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_quiet: got stb=%b cyc=%b want 0 0", STB_O, CYC_O);
        end
        stream(1, 100, 100, NDATA, "postrst", gaps);
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_ack_stall();
        test_cyc_drop();
        test_stb_gaps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
